// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and sizes for the writeback arbiter slice (package npc_pkg).
package npc_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_X0 = '0;

  typedef struct packed {
    logic            valid;
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_EXU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Issue, writeback-request and register-file write bus of reg_wb_arbiter.
// WB_FWD_EN adds the forwarding outputs fwd_rs1_hit/fwd_rs2_hit/fwd_data.
interface reg_wb_arbiter_if;
  import npc_pkg::*;

  logic            iss_valid;
  reg_idx_t        iss_rs1;
  reg_idx_t        iss_rs2;
  reg_idx_t        iss_rd;
  logic            iss_wen;
  logic            iss_ready;
  logic            exu_valid;
  reg_idx_t        exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            exu_ready;
  logic            lsu_valid;
  reg_idx_t        lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            rf_wen;
  reg_idx_t        rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            wb_err;
`ifdef WB_FWD_EN
  logic            fwd_rs1_hit;
  logic            fwd_rs2_hit;
  logic [XLEN-1:0] fwd_data;
`endif

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
`ifdef WB_FWD_EN
    input  fwd_rs1_hit, fwd_rs2_hit, fwd_data,
`endif
    input  iss_ready, exu_ready, lsu_ready, rf_wen, rf_rd, rf_wdata, wb_err
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
`ifdef WB_FWD_EN
    output fwd_rs1_hit, fwd_rs2_hit, fwd_data,
`endif
    output iss_ready, exu_ready, lsu_ready, rf_wen, rf_rd, rf_wdata, wb_err
  );

endinterface

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard: set on issue, clear on RF write, RAW/WAW issue gate.
// With WB_FWD_EN a hazard on the index being written this cycle is forwarded instead of stalled.
module wb_scoreboard
  import npc_pkg::*;
#(
  parameter int NUM_REG = NREG
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     iss_valid,
  input  reg_idx_t iss_rs1,
  input  reg_idx_t iss_rs2,
  input  reg_idx_t iss_rd,
  input  logic     iss_wen,
  input  logic     rf_wen,
  input  reg_idx_t rf_rd,
  input  reg_idx_t look_rd,
  output logic     look_pending,
`ifdef WB_FWD_EN
  output logic     fwd_rs1_hit,
  output logic     fwd_rs2_hit,
`endif
  output logic     iss_ready
);

  logic [NUM_REG-1:0] pending_r;
  logic [NUM_REG-1:0] pending_nxt_s;
  logic [NUM_REG-1:0] set_s;
  logic [NUM_REG-1:0] clr_s;
  logic hit_rs1_s, hit_rs2_s, hit_rd_s;
  logic haz_rs1_s, haz_rs2_s, haz_rd_s;

  function automatic logic busy(input logic [NUM_REG-1:0] vec, input reg_idx_t idx);
    return (idx != REG_X0) && vec[idx];
  endfunction

  // Hazard check, forwarding match and next pending vector (set beats clear).
  always_comb begin
    hit_rs1_s = 1'b0;
    hit_rs2_s = 1'b0;
    hit_rd_s  = 1'b0;
`ifdef WB_FWD_EN
    hit_rs1_s = rf_wen && (rf_rd == iss_rs1) && (iss_rs1 != REG_X0);
    hit_rs2_s = rf_wen && (rf_rd == iss_rs2) && (iss_rs2 != REG_X0);
    hit_rd_s  = rf_wen && (rf_rd == iss_rd)  && (iss_rd  != REG_X0);
`endif
    haz_rs1_s = busy(pending_r, iss_rs1) && !hit_rs1_s;
    haz_rs2_s = busy(pending_r, iss_rs2) && !hit_rs2_s;
    haz_rd_s  = iss_wen && busy(pending_r, iss_rd) && !hit_rd_s;
    iss_ready = !(haz_rs1_s || haz_rs2_s || haz_rd_s);

    set_s = '0;
    clr_s = '0;
    if (iss_valid && iss_ready && iss_wen && (iss_rd != REG_X0)) begin
      set_s[iss_rd] = 1'b1;
    end else begin
      set_s = '0;
    end
    if (rf_wen) begin
      clr_s[rf_rd] = 1'b1;
    end else begin
      clr_s = '0;
    end
    pending_nxt_s = (pending_r & ~clr_s) | set_s;
    look_pending  = pending_r[look_rd];
  end

`ifdef WB_FWD_EN
  assign fwd_rs1_hit = hit_rs1_s;
  assign fwd_rs2_hit = hit_rs2_s;
`endif

  // Pending-destination register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin EXU/LSU writeback arbiter onto one registered register-file write port.
// Optional macro WB_FWD_EN: same-cycle forwarding of the write port to issue.
module reg_wb_arbiter #(
  parameter int XLEN = npc_pkg::XLEN,
  parameter int NREG = npc_pkg::NREG
) (
  input logic             clk,
  input logic             rst,
  reg_wb_arbiter_if.slave bus
);

  npc_pkg::wb_src_e  rr_ptr_r;
  npc_pkg::wb_req_t  exu_req_s;
  npc_pkg::wb_req_t  lsu_req_s;
  npc_pkg::wb_req_t  gnt_req_s;
  logic              gnt_exu_s;
  logic              gnt_lsu_s;
  logic              gnt_pending_s;
  logic              rf_wen_r;
  npc_pkg::reg_idx_t rf_rd_r;
  logic [XLEN-1:0]   rf_wdata_r;
  logic              wb_err_r;

  assign exu_req_s = '{valid: bus.exu_valid, rd: bus.exu_rd, data: bus.exu_data};
  assign lsu_req_s = '{valid: bus.lsu_valid, rd: bus.lsu_rd, data: bus.lsu_data};

  // Grant selection: a lone requester always wins, a tie goes to rr_ptr.
  always_comb begin
    gnt_exu_s = 1'b0;
    gnt_lsu_s = 1'b0;
    gnt_req_s = '0;
    if (exu_req_s.valid && (!lsu_req_s.valid || (rr_ptr_r == npc_pkg::WB_EXU))) begin
      gnt_exu_s = 1'b1;
      gnt_req_s = exu_req_s;
    end else if (lsu_req_s.valid) begin
      gnt_lsu_s = 1'b1;
      gnt_req_s = lsu_req_s;
    end else begin
      gnt_req_s = '0;
    end
  end

  // Round-robin pointer flips to the other source after every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= npc_pkg::WB_EXU;
    end else if (gnt_exu_s) begin
      rr_ptr_r <= npc_pkg::WB_LSU;
    end else if (gnt_lsu_s) begin
      rr_ptr_r <= npc_pkg::WB_EXU;
    end
  end

  // Write port and sticky error; x0 writes are consumed without a write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_r   <= 1'b0;
      rf_rd_r    <= npc_pkg::REG_X0;
      rf_wdata_r <= '0;
      wb_err_r   <= 1'b0;
    end else begin
      rf_wen_r <= gnt_req_s.valid && (gnt_req_s.rd != npc_pkg::REG_X0);
      if (gnt_req_s.valid) begin
        rf_rd_r    <= gnt_req_s.rd;
        rf_wdata_r <= gnt_req_s.data;
      end
      if (gnt_req_s.valid && (gnt_req_s.rd != npc_pkg::REG_X0) && !gnt_pending_s) begin
        wb_err_r <= 1'b1;
      end
    end
  end

  wb_scoreboard #(
    .NUM_REG (NREG)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .iss_valid    (bus.iss_valid),
    .iss_rs1      (bus.iss_rs1),
    .iss_rs2      (bus.iss_rs2),
    .iss_rd       (bus.iss_rd),
    .iss_wen      (bus.iss_wen),
    .rf_wen       (rf_wen_r),
    .rf_rd        (rf_rd_r),
    .look_rd      (gnt_req_s.rd),
    .look_pending (gnt_pending_s),
`ifdef WB_FWD_EN
    .fwd_rs1_hit  (bus.fwd_rs1_hit),
    .fwd_rs2_hit  (bus.fwd_rs2_hit),
`endif
    .iss_ready    (bus.iss_ready)
  );

  assign bus.exu_ready = gnt_exu_s;
  assign bus.lsu_ready = gnt_lsu_s;
  assign bus.rf_wen    = rf_wen_r;
  assign bus.rf_rd     = rf_rd_r;
  assign bus.rf_wdata  = rf_wdata_r;
  assign bus.wb_err    = wb_err_r;
`ifdef WB_FWD_EN
  assign bus.fwd_data  = rf_wdata_r;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: per-cycle comparison against a scoreboard/arbiter
// model plus hand-computed checkpoints. Builds with or without WB_FWD_EN.
module tb_reg_wb_arbiter;
  import npc_pkg::*;

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wb_arbiter_if bus();
  reg_wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the spec says the block holds right now.
  bit          mpend [NREG];
  bit          m_fav_lsu;
  bit          m_wen;
  reg_idx_t    m_rd;
  logic [31:0] m_data;
  bit          m_err;
  bit          m_live = 1'b0;
  bit          e_iss, e_exu, e_lsu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit blocked(input reg_idx_t idx);
    if (idx == 5'd0 || !mpend[idx]) return 1'b0;
    if (FWD && m_wen && m_rd == idx) return 1'b0;
    return 1'b1;
  endfunction

  task automatic at_neg();
    @(negedge clk);
    if (m_live) begin
      e_iss = !(blocked(bus.iss_rs1) || blocked(bus.iss_rs2) || (bus.iss_wen && blocked(bus.iss_rd)));
      if (bus.exu_valid && bus.lsu_valid) begin
        e_exu = !m_fav_lsu;
        e_lsu = m_fav_lsu;
      end else begin
        e_exu = bus.exu_valid;
        e_lsu = bus.lsu_valid;
      end
      chk("iss_ready", 64'(bus.iss_ready), 64'(e_iss));
      chk("exu_ready", 64'(bus.exu_ready), 64'(e_exu));
      chk("lsu_ready", 64'(bus.lsu_ready), 64'(e_lsu));
      chk("rf_wen", 64'(bus.rf_wen), 64'(m_wen));
      chk("rf_rd", 64'(bus.rf_rd), 64'(m_rd));
      chk("rf_wdata", 64'(bus.rf_wdata), 64'(m_data));
      chk("wb_err", 64'(bus.wb_err), 64'(m_err));
`ifdef WB_FWD_EN
      chk("fwd_rs1_hit", 64'(bus.fwd_rs1_hit), 64'(m_wen && m_rd == bus.iss_rs1 && bus.iss_rs1 != 5'd0));
      chk("fwd_rs2_hit", 64'(bus.fwd_rs2_hit), 64'(m_wen && m_rd == bus.iss_rs2 && bus.iss_rs2 != 5'd0));
      chk("fwd_data", 64'(bus.fwd_data), 64'(m_data));
`endif
    end
  endtask

  task automatic advance();
    bit          gnt;
    reg_idx_t    grd;
    logic [31:0] gdata;
    if (rst) begin
      foreach (mpend[i]) mpend[i] = 1'b0;
      m_fav_lsu = 1'b0;
      m_wen     = 1'b0;
      m_rd      = 5'd0;
      m_data    = 32'd0;
      m_err     = 1'b0;
      m_live    = 1'b1;
    end else if (m_live) begin
      gnt   = e_exu || e_lsu;
      grd   = e_exu ? bus.exu_rd : bus.lsu_rd;
      gdata = e_exu ? bus.exu_data : bus.lsu_data;
      if (gnt && grd != 5'd0 && !mpend[grd]) m_err = 1'b1;
      if (m_wen) mpend[m_rd] = 1'b0;
      if (bus.iss_valid && e_iss && bus.iss_wen && bus.iss_rd != 5'd0) mpend[bus.iss_rd] = 1'b1;
      if (e_exu) m_fav_lsu = 1'b1;
      else if (e_lsu) m_fav_lsu = 1'b0;
      if (gnt) begin
        m_wen  = (grd != 5'd0);
        m_rd   = grd;
        m_data = gdata;
      end else begin
        m_wen = 1'b0;
      end
    end
  endtask

  task automatic post();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    at_neg();
    post();
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_wen = 1'b0;
    bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0; bus.iss_rd = 5'd0;
    bus.exu_valid = 1'b0; bus.exu_rd = 5'd0; bus.exu_data = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic wen);
    bus.iss_valid = 1'b1;
    bus.iss_rs1 = rs1; bus.iss_rs2 = rs2; bus.iss_rd = rd; bus.iss_wen = wen;
  endtask

  initial begin
    int  ei, li;
    bit  ge, gl;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    at_neg();
    chk("rst_rf_wen", 64'(bus.rf_wen), 64'd0);
    chk("rst_wb_err", 64'(bus.wb_err), 64'd0);
    chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst_iss_ready", 64'(bus.iss_ready), 64'd1);
    post();

    // RAW on x5: stall until the cycle after the write (same cycle when forwarding)
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    at_neg(); chk("raw_first_issue", 64'(bus.iss_ready), 64'd1); post();
    issue(5'd5, 5'd0, 5'd0, 1'b0);
    at_neg(); chk("raw_stall", 64'(bus.iss_ready), 64'd0); post();
    tick();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'h0000_5555;
    at_neg(); chk("raw_exu_gnt", 64'(bus.exu_ready), 64'd1); chk("raw_stall2", 64'(bus.iss_ready), 64'd0); post();
    bus.exu_valid = 1'b0;
    at_neg();
    chk("raw_wb_wen", 64'(bus.rf_wen), 64'd1);
    chk("raw_wb_rd", 64'(bus.rf_rd), 64'd5);
    chk("raw_wb_cycle_ready", 64'(bus.iss_ready), 64'(FWD));
    post();
    at_neg(); chk("raw_after_wb", 64'(bus.iss_ready), 64'd1); post();
    idle();

    // Arbitration order after reset: EXU first, then LSU
    rst = 1'b1; tick(); rst = 1'b0;
    issue(5'd0, 5'd0, 5'd5, 1'b1); tick();
    issue(5'd0, 5'd0, 5'd6, 1'b1); tick();
    idle();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'hDEAD_BEEF;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h1234_5678;
    at_neg(); chk("arb_exu_first", 64'(bus.exu_ready), 64'd1); chk("arb_lsu_wait", 64'(bus.lsu_ready), 64'd0); post();
    bus.exu_valid = 1'b0;
    at_neg();
    chk("arb_lsu_second", 64'(bus.lsu_ready), 64'd1);
    chk("arb_n1_wen", 64'(bus.rf_wen), 64'd1);
    chk("arb_n1_rd", 64'(bus.rf_rd), 64'd5);
    chk("arb_n1_data", 64'(bus.rf_wdata), 64'hDEAD_BEEF);
    post();
    bus.lsu_valid = 1'b0;
    at_neg();
    chk("arb_n2_rd", 64'(bus.rf_rd), 64'd6);
    chk("arb_n2_data", 64'(bus.rf_wdata), 64'h1234_5678);
    chk("arb_no_err", 64'(bus.wb_err), 64'd0);
    post();

    // Continuous contention: E,L,E,L,E,L
    for (int r = 10; r < 18; r++) begin
      issue(5'd0, 5'd0, 5'(r), 1'b1);
      tick();
    end
    idle();
    ei = 0; li = 0;
    for (int c = 0; c < 6; c++) begin
      bus.exu_valid = 1'b1; bus.exu_rd = 5'(10 + 2 * ei); bus.exu_data = 32'hE000_0000 + 32'(ei);
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(11 + 2 * li); bus.lsu_data = 32'hC000_0000 + 32'(li);
      at_neg();
      chk("alt_exu", 64'(bus.exu_ready), 64'(c % 2 == 0));
      chk("alt_lsu", 64'(bus.lsu_ready), 64'(c % 2 == 1));
      ge = bus.exu_ready; gl = bus.lsu_ready;
      post();
      if (ge) ei++;
      if (gl) li++;
    end
    idle();
    tick();

    // Write to x0 is consumed silently
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFF_FFFF;
    at_neg(); chk("x0_gnt", 64'(bus.lsu_ready), 64'd1); post();
    bus.lsu_valid = 1'b0;
    issue(5'd0, 5'd0, 5'd0, 1'b0);
    at_neg();
    chk("x0_no_wen", 64'(bus.rf_wen), 64'd0);
    chk("x0_no_err", 64'(bus.wb_err), 64'd0);
    chk("x0_no_hazard", 64'(bus.iss_ready), 64'd1);
    post();
    idle();

    // Write to non-pending x9 raises the sticky error
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h0000_0099;
    tick();
    bus.exu_valid = 1'b0;
    at_neg(); chk("err_wen", 64'(bus.rf_wen), 64'd1); chk("err_set", 64'(bus.wb_err), 64'd1); post();
    tick(); tick();
    at_neg(); chk("err_sticky", 64'(bus.wb_err), 64'd1); post();

    // Reset during an active grant
    issue(5'd0, 5'd0, 5'd20, 1'b1); tick();
    idle();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd20; bus.exu_data = 32'h2020_2020;
    rst = 1'b1; tick(); rst = 1'b0;
    idle();
    issue(5'd20, 5'd0, 5'd0, 1'b0);
    at_neg();
    chk("rstmid_wen", 64'(bus.rf_wen), 64'd0);
    chk("rstmid_err", 64'(bus.wb_err), 64'd0);
    chk("rstmid_pend_clr", 64'(bus.iss_ready), 64'd1);
    post();
    idle();

    // Forwarding window on x7 (rs2 read plus WAW on rd=7)
    issue(5'd0, 5'd0, 5'd7, 1'b1); tick();
    issue(5'd0, 5'd7, 5'd7, 1'b1);
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'hA5A5_A5A5;
    at_neg(); chk("fwd_exu_gnt", 64'(bus.exu_ready), 64'd1); chk("fwd_pre_stall", 64'(bus.iss_ready), 64'd0); post();
    bus.exu_valid = 1'b0;
    at_neg();
    chk("fwd_wb_rd", 64'(bus.rf_rd), 64'd7);
    chk("fwd_wb_cycle_ready", 64'(bus.iss_ready), 64'(FWD));
`ifdef WB_FWD_EN
    chk("fwd_rs2_hit_lit", 64'(bus.fwd_rs2_hit), 64'd1);
    chk("fwd_data_lit", 64'(bus.fwd_data), 64'hA5A5_A5A5);
`endif
    post();
    at_neg(); chk("fwd_next_ready", 64'(bus.iss_ready), 64'(!FWD)); post();
    issue(5'd7, 5'd0, 5'd0, 1'b0);
    at_neg(); chk("fwd_pend_kept", 64'(bus.iss_ready), 64'd0); post();
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Sequences the register file's single write port and tracks outstanding destination registers.
- Writeback requests come from EXU (ALU/CSR results) and LSU (load data) and are arbitrated round-robin onto one registered write port (rf_wen/rf_rd/rf_wdata).
- A pending-write scoreboard gates instruction issue on RAW/WAW hazards.
- Sits between IDU/EXU/LSU and the register file.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; register index width is $clog2(NREG).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  IDU presents an instruction.
- iss_rs1  in  5  source 1 index.
- iss_rs2  in  5  source 2 index.
- iss_rd  in  5  destination index.
- iss_wen  in  1  instruction writes rd.
- iss_ready  out  1  no hazard; issue handshake = iss_valid & iss_ready.
- exu_valid  in  1  EXU writeback request.
- exu_rd  in  5  EXU destination.
- exu_data  in  XLEN  EXU result.
- exu_ready  out  1  EXU request granted this cycle.
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  5  LSU destination.
- lsu_data  in  XLEN  load result.
- lsu_ready  out  1  LSU request granted this cycle.
- rf_wen  out  1  register file write enable.
- rf_rd  out  5  register file write index.
- rf_wdata  out  XLEN  register file write data.
- wb_err  out  1  sticky: writeback to a register that was not pending.

Behaviour:
- Reset: pending[NREG-1:0]=0, rr_ptr=0 (EXU favoured), rf_wen=0, rf_rd=0, rf_wdata=0, wb_err=0. In-flight grants are dropped.
- Reset mid-operation: the same state applies on the clock edge where rst=1. Requesters must re-present after reset.
- Arbitration (combinational ready, one grant per cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by rr_ptr wins (0=EXU, 1=LSU).
  - On any grant, rr_ptr moves to point at the other requester.
  - Request inputs must stay stable until ready.
- Write port latency is 1 cycle. A grant in cycle N registers rf_wen=(rd!=0), rf_rd, rf_wdata for cycle N+1. With no grant in N, rf_wen=0 in N+1 and rf_rd/rf_wdata hold their previous values.
- Register x0:
  - Granted writes to rd=0 are consumed with rf_wen=0.
  - pending[0] is never set.
  - x0 is never a hazard.
- Scoreboard:
  - On issue with iss_wen=1 and iss_rd!=0, set pending[iss_rd].
  - When rf_wen=1, clear pending[rf_rd] on that edge.
  - Set and clear of the same index on one edge: set wins. This case cannot arise without WB_FWD_EN, because iss_ready blocks it.
- Hazard check: iss_ready = ~(pending[rs1] | pending[rs2] | (iss_wen & pending[iss_rd])), with index 0 masked out. iss_ready does not depend on iss_valid.
- wb_err: set when a granted request has rd!=0 and pending[rd]=0. It stays set until reset. The write is still performed.
- Simultaneous events: an issue, an EXU grant and an LSU request may all occur in one cycle. Only one writeback is granted; the other stalls.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - In the cycle rf_wen=1, a hazard whose index equals rf_rd is not a stall. This covers rs1, rs2 and WAW on rd.
  - Adds outputs fwd_rs1_hit, fwd_rs2_hit (1 bit) and fwd_data (XLEN = rf_wdata). Consumers mux fwd_data over the regfile read.
  - A same-edge set+clear of that index leaves pending=1.
- Undefined:
  - No forwarding ports.
  - Issue waits until the cycle after rf_wen, when the regfile holds the new value.

Decomposition:
- Shared package npc_pkg:
  - XLEN, NREG, REG_IDX_W.
  - Typedef reg_idx_t.
  - Typedef wb_req_t {valid, rd, data}.
  - Enum wb_src_e {WB_EXU=0, WB_LSU=1}.
- One sub-module: wb_scoreboard. It holds the pending vector, set/clear logic, hazard check and forwarding hit compare. The arbiter and write-port registers stay in reg_wb_arbiter.

Test Plan:
- Reset, then issue rd=5 with rs1=rs2=0 → pending[5]=1. A following issue reading rs1=5 sees iss_ready=0 until the cycle after rf_wen with rf_rd=5.
- EXU rd=5 data=0xDEADBEEF and LSU rd=6 data=0x12345678 valid in the same cycle after reset → EXU granted first: rf_wen, rd=5, 0xDEADBEEF in N+1. Then LSU: rd=6, 0x12345678 in N+2.
- EXU and LSU both valid continuously for 6 cycles, all rd pending → grants alternate E,L,E,L,E,L with no cycle skipped.
- Granted write to rd=0 → rf_wen=0, pending unchanged, wb_err=0. Issue with rs1=0 → iss_ready=1.
- EXU writes rd=9 while pending[9]=0 → rf_wen=1 and wb_err=1, held until rst. Assert rst during an active grant → next cycle rf_wen=0 and pending=0.
- WB_FWD_EN: rf_wen=1, rf_rd=7, rf_wdata=0xA5A5A5A5 and issue rs2=7 in the same cycle → iss_ready=1, fwd_rs2_hit=1, fwd_data=0xA5A5A5A5. Without the macro → iss_ready=0 that cycle, then 1 the next.
